// File: rtl/dcpu_bus_pkg.sv
// rtl/dcpu_bus_pkg.sv - shared encodings and constants for the dcpu bus arbiter
package dcpu_bus_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  localparam logic [15:0] TIMEOUT_FILL = 16'h0000;

  function automatic logic [1:0] master_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dcpu_rr_pick.sv
// rtl/dcpu_rr_pick.sv - combinational 2-way picker, round-robin or fixed priority
import dcpu_bus_pkg::*;

module dcpu_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      // contention: CPU wins when fixed, otherwise whoever was not served last
      2'b11:   pick = (fixed || (last == M_AUX)) ? master_onehot(M_CPU) : master_onehot(M_AUX);
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/dcpu_bus_arbiter.sv
// rtl/dcpu_bus_arbiter.sv - two-master arbiter for the 16-bit dcpu memory port
// Optional ack watchdog enabled by defining DCPU_ARB_TIMEOUT_EN.
import dcpu_bus_pkg::*;

module dcpu_bus_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT_W  = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_m0_addr,
  input  logic [15:0] i_m0_dat,
  input  logic        i_m0_we,
  input  logic        i_m0_cs,
  output logic [15:0] o_m0_dat,
  output logic        o_m0_ack,
  input  logic [15:0] i_m1_addr,
  input  logic [15:0] i_m1_dat,
  input  logic        i_m1_we,
  input  logic        i_m1_cs,
  output logic [15:0] o_m1_dat,
  output logic        o_m1_ack,
  output logic [15:0] o_addr,
  output logic [15:0] o_dat,
  output logic        o_we,
  output logic        o_cs,
  input  logic [15:0] i_dat,
  input  logic        i_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  arb_state_t r_state, nxt_state;
  logic [1:0] r_grant, nxt_grant;
  logic       r_last, nxt_last;
  logic [1:0] pick;
  logic       sel;
  logic       busy;
  logic       g_cs;
  logic       real_ack;
  logic       to_hit;

  dcpu_rr_pick u_pick (
    .req   ({i_m1_cs, i_m0_cs}),
    .last  (r_last),
    .fixed (FIXED_PRIO != 0),
    .pick  (pick)
  );

  assign sel      = r_grant[1];
  assign busy     = (r_state == ARB_BUSY);
  assign g_cs     = busy & (sel ? i_m1_cs : i_m0_cs);
  assign real_ack = g_cs & i_ack;

`ifdef DCPU_ARB_TIMEOUT_EN
  // r_cnt counts completed ack-less BUSY cycles; the 2^W-1'th such cycle expires
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (!busy) begin
      r_cnt <= '0;
    end else if (!i_ack) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign to_hit = g_cs & ~i_ack & (r_cnt == CNT_LAST);
`else
  assign to_hit = 1'b0;
`endif

  assign o_timeout = to_hit;
  assign o_grant   = r_grant;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ARB_IDLE;
      r_grant <= 2'b00;
      r_last  <= M_AUX;
    end else begin
      r_state <= nxt_state;
      r_grant <= nxt_grant;
      r_last  <= nxt_last;
    end
  end

  always_comb begin
    nxt_state = r_state;
    nxt_grant = r_grant;
    nxt_last  = r_last;
    case (r_state)
      ARB_IDLE: begin
        if (pick != 2'b00) begin
          nxt_grant = pick;
          nxt_state = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // a withdrawn cs is an abort and does not count as service
        if (!g_cs) begin
          nxt_state = ARB_IDLE;
          nxt_grant = 2'b00;
        end else if (real_ack || to_hit) begin
          nxt_state = ARB_IDLE;
          nxt_grant = 2'b00;
          nxt_last  = sel;
        end
      end
      default: begin
        nxt_state = ARB_IDLE;
        nxt_grant = 2'b00;
      end
    endcase
  end

  always_comb begin
    o_addr   = 16'h0000;
    o_dat    = 16'h0000;
    o_we     = 1'b0;
    o_cs     = 1'b0;
    o_m0_dat = 16'h0000;
    o_m0_ack = 1'b0;
    o_m1_dat = 16'h0000;
    o_m1_ack = 1'b0;
    if (busy) begin
      if (sel == M_AUX) begin
        o_addr   = i_m1_addr;
        o_dat    = i_m1_dat;
        o_we     = i_m1_we;
        o_cs     = i_m1_cs;
        o_m1_dat = to_hit ? TIMEOUT_FILL : i_dat;
        o_m1_ack = real_ack | to_hit;
      end else begin
        o_addr   = i_m0_addr;
        o_dat    = i_m0_dat;
        o_we     = i_m0_we;
        o_cs     = i_m0_cs;
        o_m0_dat = to_hit ? TIMEOUT_FILL : i_dat;
        o_m0_ack = real_ack | to_hit;
      end
    end
  end

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// tb/tb_dcpu_bus_arbiter.sv - self-checking bench for dcpu_bus_arbiter
module tb_dcpu_bus_arbiter;

  localparam int TW = 4;
`ifdef DCPU_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [15:0] m0_addr, m0_dat, m1_addr, m1_dat, s_dat;
  logic m0_we, m0_cs, m1_we, m1_cs, s_ack;

  logic [15:0] o_m0_dat, o_m1_dat, o_addr, o_dat;
  logic o_m0_ack, o_m1_ack, o_we, o_cs, o_timeout;
  logic [1:0] o_grant;

  logic [15:0] fp_m0_dat, fp_m1_dat, fp_addr, fp_dat;
  logic fp_m0_ack, fp_m1_ack, fp_we, fp_cs, fp_timeout;
  logic [1:0] fp_grant;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: who owns the bus, who was served last, how long the owner has waited
  int owner;
  int last;
  int bcyc;
  logic e_a0 = 1'b0;
  logic e_a1 = 1'b0;
  logic m_done;

  always #5 clk = ~clk;

  dcpu_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT_W(TW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_addr(m0_addr), .i_m0_dat(m0_dat), .i_m0_we(m0_we), .i_m0_cs(m0_cs),
    .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack),
    .i_m1_addr(m1_addr), .i_m1_dat(m1_dat), .i_m1_we(m1_we), .i_m1_cs(m1_cs),
    .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack),
    .o_addr(o_addr), .o_dat(o_dat), .o_we(o_we), .o_cs(o_cs),
    .i_dat(s_dat), .i_ack(s_ack), .o_grant(o_grant), .o_timeout(o_timeout)
  );

  dcpu_bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT_W(TW)) dut_fp (
    .i_clk(clk), .i_reset(rst),
    .i_m0_addr(m0_addr), .i_m0_dat(m0_dat), .i_m0_we(m0_we), .i_m0_cs(m0_cs),
    .o_m0_dat(fp_m0_dat), .o_m0_ack(fp_m0_ack),
    .i_m1_addr(m1_addr), .i_m1_dat(m1_dat), .i_m1_we(m1_we), .i_m1_cs(m1_cs),
    .o_m1_dat(fp_m1_dat), .o_m1_ack(fp_m1_ack),
    .o_addr(fp_addr), .o_dat(fp_dat), .o_we(fp_we), .o_cs(fp_cs),
    .i_dat(s_dat), .i_ack(s_ack), .o_grant(fp_grant), .o_timeout(fp_timeout)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    last  = 1;
    bcyc  = 1;
    e_a0  = 1'b0;
    e_a1  = 1'b0;
  endtask

  // called just after inputs change at the falling edge
  task automatic settle();
    logic [15:0] x_addr, x_dat, x_d0, x_d1;
    logic x_we, x_cs, x_to, rcs, ra;
    logic [1:0] x_g;
    #1;
    x_addr = '0; x_dat = '0; x_d0 = '0; x_d1 = '0;
    x_we = 0; x_cs = 0; x_to = 0; x_g = 2'b00;
    e_a0 = 0; e_a1 = 0; m_done = 0;
    if (owner >= 0) begin
      rcs    = (owner == 1) ? m1_cs : m0_cs;
      x_addr = (owner == 1) ? m1_addr : m0_addr;
      x_dat  = (owner == 1) ? m1_dat : m0_dat;
      x_we   = (owner == 1) ? m1_we : m0_we;
      x_cs   = rcs;
      x_g    = (owner == 1) ? 2'b10 : 2'b01;
      ra     = rcs && s_ack;
      x_to   = TO_EN && rcs && !s_ack && (bcyc == (1 << TW) - 1);
      m_done = ra || x_to;
      if (owner == 1) begin
        e_a1 = m_done;
        x_d1 = x_to ? 16'h0000 : s_dat;
      end else begin
        e_a0 = m_done;
        x_d0 = x_to ? 16'h0000 : s_dat;
      end
    end
    check("grant",   16'(o_grant),   16'(x_g));
    check("cs",      16'(o_cs),      16'(x_cs));
    check("addr",    o_addr,         x_addr);
    check("wdat",    o_dat,          x_dat);
    check("we",      16'(o_we),      16'(x_we));
    check("m0_ack",  16'(o_m0_ack),  16'(e_a0));
    check("m1_ack",  16'(o_m1_ack),  16'(e_a1));
    check("m0_dat",  o_m0_dat,       x_d0);
    check("m1_dat",  o_m1_dat,       x_d1);
    check("timeout", 16'(o_timeout), 16'(x_to));
  endtask

  task automatic adv();
    if (owner < 0) begin
      if (m0_cs && m1_cs) owner = 1 - last;
      else if (m0_cs)     owner = 0;
      else if (m1_cs)     owner = 1;
      bcyc = 1;
    end else if (!((owner == 1) ? m1_cs : m0_cs)) begin
      owner = -1;
    end else if (m_done) begin
      last  = owner;
      owner = -1;
    end else begin
      bcyc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_addr = '0; m0_dat = '0; m0_we = 0; m0_cs = 0;
    m1_addr = '0; m1_dat = '0; m1_we = 0; m1_cs = 0;
    s_dat = '0; s_ack = 0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    settle();
    rst = 1'b0;
    adv();
  endtask

  logic [1:0] rr_seq [6];
  logic [1:0] fp_seq [6];

  initial begin
    rr_seq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    fp_seq = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    clear_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    settle();
    check("fp_reset_grant", 16'(fp_grant), 16'h0000);
    check("fp_reset_cs", 16'(fp_cs), 16'h0000);
    rst = 1'b0;
    adv();

    // single-master read
    m0_cs = 1; m0_addr = 16'h1234;
    settle();
    adv();
    s_ack = 1; s_dat = 16'hBEEF;
    settle();
    check("rd_addr", o_addr, 16'h1234);
    check("rd_data", o_m0_dat, 16'hBEEF);
    check("rd_ack", 16'(o_m0_ack), 16'h0001);
    adv();
    m0_cs = 0; s_ack = 0;
    settle();
    check("rd_ack_once", 16'(o_m0_ack), 16'h0000);
    adv();

    // m1 write
    m1_cs = 1; m1_we = 1; m1_addr = 16'h8000; m1_dat = 16'h00AA;
    settle();
    check("wr_we_idle", 16'(o_we), 16'h0000);
    adv();
    settle();
    check("wr_we", 16'(o_we), 16'h0001);
    check("wr_dat", o_dat, 16'h00AA);
    check("wr_addr", o_addr, 16'h8000);
    adv();
    s_ack = 1;
    settle();
    adv();
    m1_cs = 0; m1_we = 0; s_ack = 0;
    settle();
    check("wr_addr_after", o_addr, 16'h0000);
    adv();

    // contention from reset, slave acks every cycle
    clear_inputs();
    pulse_reset();
    m0_cs = 1; m1_cs = 1; s_ack = 1; s_dat = 16'h0F0F;
    for (int i = 0; i < 6; i++) begin
      settle();
      check("rr_grant_seq", 16'(o_grant), 16'(rr_seq[i]));
      check("fp_grant_seq", 16'(fp_grant), 16'(fp_seq[i]));
      check("fp_m1_starve", 16'(fp_m1_ack), 16'h0000);
      adv();
    end

    // abort by m0 with m1 pending
    clear_inputs();
    pulse_reset();
    m0_cs = 1; m0_addr = 16'h0100;
    settle();
    adv();
    m1_cs = 1; m1_addr = 16'h0200;
    settle();
    check("abort_granted", 16'(o_grant), 16'h0001);
    adv();
    m0_cs = 0;
    settle();
    check("abort_cs", 16'(o_cs), 16'h0000);
    check("abort_noack", 16'(o_m0_ack), 16'h0000);
    adv();
    settle();
    check("abort_idle", 16'(o_grant), 16'h0000);
    adv();
    settle();
    check("abort_m1_grant", 16'(o_grant), 16'h0002);
    s_ack = 1;
    settle();
    adv();
    clear_inputs();
    settle();
    adv();

    // reset between edges during BUSY
    m0_cs = 1; m0_addr = 16'h4444;
    settle();
    adv();
    settle();
    check("rstmid_busy_cs", 16'(o_cs), 16'h0001);
    s_ack = 1;
    rst = 1;
    #1;
    check("rstmid_cs", 16'(o_cs), 16'h0000);
    check("rstmid_grant", 16'(o_grant), 16'h0000);
    check("rstmid_ack", 16'(o_m0_ack), 16'h0000);
    model_reset();
    rst = 0;
    clear_inputs();
    settle();
    adv();

`ifdef DCPU_ARB_TIMEOUT_EN
    // watchdog expiry, then a real ack landing in the expiry cycle
    for (int pass = 0; pass < 2; pass++) begin
      m0_cs = 1; m0_addr = 16'h0777; s_dat = 16'h5555;
      settle();
      adv();
      for (int i = 1; i <= 15; i++) begin
        s_ack = (pass == 1 && i == 15);
        settle();
        if (i == 15) begin
          check("to_ack", 16'(o_m0_ack), 16'h0001);
          check("to_pulse", 16'(o_timeout), (pass == 0) ? 16'h0001 : 16'h0000);
          check("to_data", o_m0_dat, (pass == 0) ? 16'h0000 : 16'h5555);
        end
        adv();
      end
      clear_inputs();
      settle();
      adv();
    end
`endif

    // randomized traffic against the model
    clear_inputs();
    for (int c = 0; c < 400; c++) begin
      if (m0_cs && (e_a0 || $urandom_range(0, 19) == 0)) m0_cs = 0;
      else if (!m0_cs && $urandom_range(0, 2) == 0) begin
        m0_cs = 1; m0_addr = 16'($urandom); m0_dat = 16'($urandom); m0_we = 1'($urandom);
      end
      if (m1_cs && (e_a1 || $urandom_range(0, 19) == 0)) m1_cs = 0;
      else if (!m1_cs && $urandom_range(0, 2) == 0) begin
        m1_cs = 1; m1_addr = 16'($urandom); m1_dat = 16'($urandom); m1_we = 1'($urandom);
      end
      s_ack = ($urandom_range(0, 2) == 0);
      s_dat = 16'($urandom);
      settle();
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
